// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud-period helper
// used by both TX and RX so their bit timing always agrees.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;

  function automatic int bit_period(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, decoded byte and strobes out.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done;
  logic       frame_err;

  modport master (output rx, input data_out, input rx_done, input frame_err);
  modport slave  (input rx, output data_out, output rx_done, output frame_err);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable
// reset value so idle-high and idle-low lines both come out of reset quiet.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start bit validated at mid-bit, data and stop sampled at
// bit centres, one-cycle rx_done / frame_err strobes per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  localparam int          BIT_PERIOD  = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int          HALF_PERIOD = BIT_PERIOD / 2;
  localparam logic [15:0] BIT_LAST    = 16'(BIT_PERIOD - 1);
  localparam logic [15:0] HALF_LAST   = 16'(HALF_PERIOD - 1);

  logic        w_rx_s;
  uart_state_t r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shreg;
  logic [7:0]  r_data_out;
  logic        r_rx_done;
  logic        r_frame_err;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 16'd0;
      r_idx       <= 3'd0;
      r_shreg     <= 8'h00;
      r_data_out  <= 8'h00;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_cnt   <= 16'd0;
          end
        end
        ST_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= 16'd0;
            r_idx <= 3'd0;
            // a line already back high at mid-start was a glitch, not a frame
            r_state <= w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_shreg <= {w_rx_s, r_shreg[7:1]};
            r_cnt   <= 16'd0;
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= 16'd0;
            if (w_rx_s) begin
              r_data_out <= r_shreg;
              r_rx_done  <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_RECOVER;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_RECOVER: begin
          // hold off until the line idles so a break reports only once
          if (w_rx_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.rx_done   = r_rx_done;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: line-history reference model checked every cycle, plus
// directed frames with literal expectations and a randomized frame stream.
module tb_uart_rx;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int BIT      = 10;
  localparam int HALF     = 5;
  localparam int MAXE     = 30000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_if bus();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // line[e] is the rx value captured by the first sync flop at edge e
  bit         line [MAXE];
  int         ecnt = 0;
  bit         m_busy = 0, m_rec = 0;
  int         m_start = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_done = 0, m_err = 0;
  int         m_ndone = 0, m_nerr = 0;

  int         n_done = 0, n_err = 0, last_done = 0, prev_done = 0;
  logic [7:0] rxq [$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Reference: the receiver sees the line two edges late; a frame begins at
  // the first low seen while idle and every decision is at a fixed offset.
  initial begin : model_and_compare
    forever begin
      int e;
      bit s;
      @(posedge clk);
      ecnt++;
      e = ecnt;
      if (e >= MAXE) begin
        $display("FAIL edge_budget: got %0d want <%0d", e, MAXE);
        $fatal(1);
      end
      line[e] = bus.rx;
      m_done  = 0;
      m_err   = 0;
      if (reset) begin
        line[e]   = 1'b1;
        line[e-1] = 1'b1;
        m_busy    = 0;
        m_rec     = 0;
        m_data    = 8'h00;
      end else begin
        s = (e >= 2) ? line[e-2] : 1'b1;
        if (m_rec) begin
          if (s) m_rec = 0;
        end else if (!m_busy) begin
          if (!s) begin
            m_busy  = 1;
            m_start = e;
          end
        end else if (e == m_start + HALF) begin
          if (s) m_busy = 0;
        end else if (e == m_start + HALF + 9*BIT) begin
          m_busy = 0;
          if (s) begin
            for (int k = 0; k < 8; k++)
              m_data[k] = line[m_start + HALF + (k+1)*BIT - 2];
            m_done = 1;
            m_ndone++;
          end else begin
            m_err = 1;
            m_rec = 1;
            m_nerr++;
          end
        end
      end
      @(negedge clk);
      check("data_out",  int'(bus.data_out),  int'(m_data));
      check("rx_done",   int'(bus.rx_done),   int'(m_done));
      check("frame_err", int'(bus.frame_err), int'(m_err));
      if (bus.rx_done) begin
        n_done++;
        prev_done = last_done;
        last_done = e;
        rxq.push_back(bus.data_out);
      end
      if (bus.frame_err) n_err++;
    end
  end

  task automatic drive_bit(input logic v, input int n);
    bus.rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0, BIT);
    for (int k = 0; k < 8; k++) drive_bit(b[k], BIT);
    drive_bit(stop, BIT);
  endtask

  // bench-side transmitter: shifts a {stop, data, start} word out LSB first
  task automatic tx_byte(input logic [7:0] b);
    logic [9:0] w;
    w = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive_bit(w[0], BIT);
      w = w >> 1;
    end
  endtask

  initial begin : stimulus
    int d0, e0, p;
    logic [7:0] b;
    int r;
    reset  = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_data_out",  int'(bus.data_out),  0);
    check("rst_rx_done",   int'(bus.rx_done),   0);
    check("rst_frame_err", int'(bus.frame_err), 0);
    idle(5);

    // good frame with exact strobe timing
    d0 = n_done; e0 = n_err; p = ecnt;
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("good_count",  n_done - d0, 1);
    check("good_edge",   last_done, p + 3 + HALF + 9*BIT);
    check("good_data",   int'(bus.data_out), 8'hA5);
    check("good_noerr",  n_err - e0, 0);
    check("model_a5",    int'(m_data), 8'hA5);

    // start-bit glitch
    d0 = n_done; e0 = n_err;
    drive_bit(1'b0, 3);
    idle(30);
    check("glitch_done", n_done - d0, 0);
    check("glitch_err",  n_err - e0, 0);
    check("glitch_data", int'(bus.data_out), 8'hA5);

    // framing error followed by a held-low line
    send_frame(8'h11, 1'b1);
    idle(10);
    check("pre_err_data", int'(bus.data_out), 8'h11);
    d0 = n_done; e0 = n_err;
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b0, 30);
    check("err_once_low", n_err - e0, 1);
    idle(30);
    check("err_count",   n_err - e0, 1);
    check("err_nodone",  n_done - d0, 0);
    check("err_data",    int'(bus.data_out), 8'h11);

    // back-to-back frames, no idle gap
    d0 = n_done;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    check("b2b_count",   n_done - d0, 2);
    check("b2b_spacing", last_done - prev_done, 100);
    check("b2b_first",   int'(rxq[rxq.size()-2]), 8'h00);
    check("b2b_second",  int'(bus.data_out), 8'hFF);

    // reset in the middle of bit 4 of 0x5A
    d0 = n_done; e0 = n_err;
    b = 8'h5A;
    drive_bit(1'b0, BIT);
    for (int k = 0; k < 4; k++) drive_bit(b[k], BIT);
    drive_bit(b[4], 3);
    bus.rx = 1'b1;
    reset  = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("mid_rst_data", int'(bus.data_out),  0);
    check("mid_rst_done", int'(bus.rx_done),   0);
    check("mid_rst_err",  int'(bus.frame_err), 0);
    idle(5);
    send_frame(8'hC3, 1'b1);
    idle(20);
    check("post_rst_count", n_done - d0, 1);
    check("post_rst_data",  int'(bus.data_out), 8'hC3);
    check("post_rst_noerr", n_err - e0, 0);

    // loopback through the bench transmitter
    d0 = n_done; e0 = n_err;
    tx_byte(8'h55);
    idle(4);
    tx_byte(8'h80);
    idle(20);
    check("loop_count", n_done - d0, 2);
    check("loop_first", int'(rxq[rxq.size()-2]), 8'h55);
    check("loop_second", int'(rxq[rxq.size()-1]), 8'h80);
    check("loop_noerr", n_err - e0, 0);

    // randomized stream: frames, bad stops, glitches and varying gaps
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        drive_bit(1'b0, $urandom_range(1, 3));
      end else begin
        b = 8'($urandom);
        send_frame(b, (r != 1));
      end
      idle($urandom_range(0, 12));
    end
    idle(120);
    check("rand_done_total", n_done, m_ndone);
    check("rand_err_total",  n_err,  m_nerr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1, LSB first. It is the receive counterpart of the team's UART transmitter and shares its baud parameters. The block synchronises the `rx` line, validates the start bit at mid-bit, and samples 8 data bits and the stop bit at bit centres. Each completed byte is presented with a one-cycle `rx_done` strobe, or a `frame_err` strobe if the stop bit is bad. It sits between the board pin and the byte-consumer logic.

## Interface
- `CLK_FREQ`, 50000000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, line rate in bit/s.
- `BIT_PERIOD`, `CLK_FREQ/BAUD_RATE`, clocks per bit. Legal range 4..65535.
- `HALF_PERIOD`, `BIT_PERIOD/2` (integer division), clocks from start-bit detection to the start-bit centre.
- `clk`, input, 1, system clock. Every register is updated on its rising edge.
- `reset`, input, 1, synchronous, active-high. One clock with `reset` high clears all state.
- `rx`, input, 1, asynchronous serial line. Idles high.
- `data_out`, output, 8, last correctly framed byte. Holds its value until the next good frame.
- `rx_done`, output, 1, one-cycle pulse when a good frame completes and `data_out` updates.
- `frame_err`, output, 1, one-cycle pulse when the sampled stop bit is 0.

## Operation
- `rx` passes through a 2-flop synchroniser to give `rx_s`. Both flops reset to 1. The FSM only ever sees `rx_s`.
- Registers:
  - `cnt`: 16 bits, bit-time counter.
  - `idx`: 3 bits, data-bit index.
  - `shreg`: 8 bits, shift register.
  - `state`: 3 bits.
- Reset values:
  - `data_out`=0x00, `rx_done`=0, `frame_err`=0.
  - `state`=IDLE, `cnt`=0, `idx`=0, `shreg`=0x00.
- `rx_done` and `frame_err` default to 0 every cycle. They are never high together.
- States and transitions:
  - IDLE: when `rx_s`==0, go to START with `cnt`=0.
  - START: `cnt` increments each cycle. At `cnt`==`HALF_PERIOD`-1:
    - `rx_s`==0: go to DATA with `cnt`=0 and `idx`=0.
    - `rx_s`==1: glitch. Return to IDLE, with no strobe.
  - DATA: `cnt` increments each cycle. At `cnt`==`BIT_PERIOD`-1:
    - `shreg` <= {`rx_s`, `shreg`[7:1]} (LSB first).
    - `cnt`=0 and `idx`++.
    - If `idx`==7, go to STOP.
  - STOP: at `cnt`==`BIT_PERIOD`-1:
    - `rx_s`==1: `data_out`<=`shreg`, `rx_done`<=1, go to IDLE.
    - `rx_s`==0: `frame_err`<=1, `data_out` unchanged, go to RECOVER.
  - RECOVER: wait for `rx_s`==1, then go to IDLE. This stops a held-low (break) line from producing repeated errors.
- The FSM returns to IDLE at the stop-bit centre. A start bit immediately following the stop bit is therefore caught, so back-to-back frames need no idle gap.
- `cnt` compares are equality against constants truncated to 16 bits. `cnt` never wraps in legal configurations.
- Reset mid-frame discards the partial frame with no strobe. After reset the block waits for the next falling edge on `rx_s`.

## Timing
- Synchroniser latency is 2 clocks from `rx` to `rx_s`.
- Let cycle N be the first edge where the FSM samples `rx_s`==0 in IDLE. Then:
  - Start-bit check occurs at N+`HALF_PERIOD`.
  - Data bit k (k=0..7) is sampled at N+`HALF_PERIOD`+(k+1)·`BIT_PERIOD`.
  - The stop bit is sampled at N+`HALF_PERIOD`+9·`BIT_PERIOD`.
  - `rx_done`/`frame_err` is high during cycle N+`HALF_PERIOD`+9·`BIT_PERIOD`+1, for exactly one clock.
- `data_out` changes in the same cycle that `rx_done` rises.
- There is no back-pressure. The consumer must capture `data_out` before the next `rx_done`, at least 10·`BIT_PERIOD`−`HALF_PERIOD` clocks later.

## Structure
- Shared package `uart_pkg` holds:
  - the state encodings (IDLE=0, START=1, DATA=2, STOP=3, RECOVER=4);
  - the `bit_period(clk_freq, baud)` constant function, so TX and RX derive identical periods.
- One sub-module, `uart_sync2`: a 2-flop synchroniser with a reset value parameter. It is reusable for other async inputs.

## Test plan
Bench parameters: `CLK_FREQ`=1000000, `BAUD_RATE`=100000, so `BIT_PERIOD`=10 and `HALF_PERIOD`=5.
- **Good frame:** drive frame 0xA5 with stop=1 → exactly one `rx_done` pulse at the specified cycle (±1 for async edge alignment), `data_out`=0xA5, `frame_err` never high.
- **Start-bit glitch:** pulse `rx` low for 3 clocks → FSM returns to IDLE, no `rx_done`, no `frame_err`, `data_out` unchanged.
- **Framing error:** after good byte 0x11, send 0x3C with stop=0 and hold `rx` low for 30 clocks → one `frame_err` pulse, `data_out` stays 0x11, no further strobes until `rx` returns high.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap → two `rx_done` pulses 100 clocks apart, `data_out`=0x00 then 0xFF.
- **Reset mid-frame:** assert `reset` for 1 clock mid-frame (after bit 3 of 0x5A), then send 0xC3 → all outputs 0 after reset, no strobe for the aborted frame, `data_out`=0xC3.
- **Loopback:** `uart_tx` → `uart_rx` at the same parameters for 0x55 and 0x80 → received bytes match and there are no framing errors.
